wbu: RTL and testbench
======================

WBU -- requirements
Module: wbu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high; clears all state immediately on assertion, independent of clk.
REQ-003 exu_valid  input  1  execute stage presents a result/load request.
REQ-004 exu_ready  output  1  wbu accepts; transfer = exu_valid & exu_ready at rising edge.
REQ-005 exu_rd  input  4  destination register (RV32E, x0..x15).
REQ-006 exu_wen  input  1  instruction writes rd.
REQ-007 exu_data  input  32  ALU/CSR result (non-load).
REQ-008 exu_is_load  input  1  instruction is a load; data comes from LSU.
REQ-009 exu_funct3  input  3  load type: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
REQ-010 exu_addr_lo  input  2  load address bits [1:0].
REQ-011 lsu_rvalid  input  1  load data valid, single-cycle pulse.
REQ-012 lsu_rdata  input  32  aligned 32-bit word containing load data.
REQ-013 rd_wen  output  1  register-file write enable.
REQ-014 rd_addr  output  4  register-file write address.
REQ-015 rd_data  output  32  register-file write data.
REQ-016 commit  output  1  one-cycle pulse per retired instruction.
REQ-017 load_err  output  1  one-cycle pulse for illegal load funct3.
REQ-018 pend_valid  output  1  a load destination is outstanding.
REQ-019 pend_rd  output  4  outstanding load destination.
REQ-020 commit_cnt  output  32  retired-instruction counter.

Function
REQ-021 States: IDLE, WAIT_LOAD; exu_ready = 1 in IDLE, 0 in WAIT_LOAD.
REQ-022 IDLE, transfer with is_load=0: next cycle rd_wen = exu_wen & (exu_rd != 0), rd_addr = exu_rd, rd_data = exu_data, commit = 1; state stays IDLE; back-to-back transfers every cycle supported.
REQ-023 IDLE, transfer with is_load=1: capture rd, wen, funct3, addr_lo; go WAIT_LOAD; no write or commit that cycle.
REQ-024 WAIT_LOAD, lsu_rvalid=1: next cycle rd_wen/rd_addr/rd_data/commit driven per REQ-025..027; state returns IDLE; a new transfer is accepted no earlier than the cycle after.
REQ-025 Byte select: byte = lsu_rdata[8*addr_lo +: 8]; half = lsu_rdata[16*addr_lo[1] +: 16] (addr_lo[0] ignored); lw uses full word, addr_lo ignored.
REQ-026 lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
REQ-027 funct3 3, 6 or 7: rd_wen = 0, load_err = 1, commit = 1, same cycle as the would-be write.
REQ-028 rd = 0 or wen = 0: rd_wen = 0; commit still pulses; rd_addr/rd_data still updated.
REQ-029 rd_wen, commit and load_err are high for exactly one cycle per event; rd_addr/rd_data hold their last value otherwise.
REQ-030 pend_valid = 1 exactly while state = WAIT_LOAD; pend_rd = captured rd (0 when IDLE).
REQ-031 commit_cnt increments by 1 on every commit pulse, same edge that raises commit; wraps 0xFFFFFFFF -> 0.
REQ-032 lsu_rvalid in IDLE is ignored (no write, no commit, no error).
REQ-033 exu_valid while exu_ready = 0: not accepted; upstream holds.

Reset
REQ-034 On rst: state IDLE; rd_wen, commit, load_err, pend_valid = 0; rd_addr, pend_rd = 0; rd_data = 0; commit_cnt = 0; exu_ready = 1 once state is IDLE.
REQ-035 rst during WAIT_LOAD discards the outstanding load; a later lsu_rvalid is ignored per REQ-032.
REQ-036 First transfer is accepted at the first rising edge after rst deasserts.

Verification
REQ-037 ALU: transfer rd=5, wen=1, data=0x12345678 -> next cycle rd_wen=1, rd_addr=5, rd_data=0x12345678, commit=1, commit_cnt=1.
REQ-038 Load lb, addr_lo=3, rd=7; two cycles later lsu_rvalid with rdata=0x80FF0011 -> next cycle rd_data=0xFFFFFF80, rd_wen=1; pend_valid=1, pend_rd=7 during the wait; exu_ready=0 during the wait.
REQ-039 Load lhu, addr_lo=2, rdata=0xBEEF1234 -> rd_data=0x0000BEEF; load funct3=3 -> rd_wen=0, load_err=1, commit=1.
REQ-040 Transfer rd=0, data=0xFFFFFFFF, then three back-to-back ALU transfers -> first gives rd_wen=0 with commit=1; next three give rd_wen=1 on consecutive cycles; commit_cnt=4.
REQ-041 Assert rst asynchronously mid-WAIT_LOAD, release, then pulse lsu_rvalid -> outputs immediately zero, pend_valid=0, no write, commit_cnt=0.
REQ-042 Force commit_cnt to 0xFFFFFFFF, then commit one instruction -> commit_cnt=0x00000000.

Source files
------------

// File: rtl/wbu.sv
// Write-back unit: retires ALU results directly and merges load data from the
// LSU into the register file, with load byte/half extraction and a retire count.
module wbu (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [3:0]  exu_rd,
    input  logic        exu_wen,
    input  logic [31:0] exu_data,
    input  logic        exu_is_load,
    input  logic [2:0]  exu_funct3,
    input  logic [1:0]  exu_addr_lo,
    input  logic        lsu_rvalid,
    input  logic [31:0] lsu_rdata,
    output logic        rd_wen,
    output logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        commit,
    output logic        load_err,
    output logic        pend_valid,
    output logic [3:0]  pend_rd,
    output logic [31:0] commit_cnt
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    logic [0:0]  state;
    logic [3:0]  ld_rd;
    logic        ld_wen;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        xfer;
    logic        ld_done;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic        ld_bad;

    assign exu_ready  = (state == IDLE);
    assign xfer       = exu_valid & exu_ready;
    assign ld_done    = (state == WAIT_LOAD) & lsu_rvalid;
    assign pend_valid = (state == WAIT_LOAD);
    assign pend_rd    = pend_valid ? ld_rd : '0;

    // Select and extend the loaded byte/half/word according to the captured load type
    always_comb begin
        ld_byte  = lsu_rdata[7:0];
        ld_half  = ld_addr_lo[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
        ld_value = '0;
        ld_bad   = 1'b0;
        case (ld_addr_lo)
            2'd0:    ld_byte = lsu_rdata[7:0];
            2'd1:    ld_byte = lsu_rdata[15:8];
            2'd2:    ld_byte = lsu_rdata[23:16];
            default: ld_byte = lsu_rdata[31:24];
        endcase
        case (ld_funct3)
            3'd0:    ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_value = {{16{ld_half[15]}}, ld_half};
            3'd2:    ld_value = lsu_rdata;
            3'd4:    ld_value = {24'd0, ld_byte};
            3'd5:    ld_value = {16'd0, ld_half};
            default: ld_bad   = 1'b1;
        endcase
    end

    // Control state and capture of the outstanding load's attributes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ld_rd      <= '0;
            ld_wen     <= 1'b0;
            ld_funct3  <= '0;
            ld_addr_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer && exu_is_load) begin
                        state      <= WAIT_LOAD;
                        ld_rd      <= exu_rd;
                        ld_wen     <= exu_wen;
                        ld_funct3  <= exu_funct3;
                        ld_addr_lo <= exu_addr_lo;
                    end
                end
                default: begin
                    if (lsu_rvalid) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Register-file write port, retire pulses and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_wen     <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
            commit     <= 1'b0;
            load_err   <= 1'b0;
            commit_cnt <= '0;
        end else begin
            rd_wen   <= 1'b0;
            commit   <= 1'b0;
            load_err <= 1'b0;
            if (xfer && !exu_is_load) begin
                rd_wen     <= exu_wen & (exu_rd != 4'd0);
                rd_addr    <= exu_rd;
                rd_data    <= exu_data;
                commit     <= 1'b1;
                commit_cnt <= commit_cnt + 32'd1;
            end else if (ld_done) begin
                commit     <= 1'b1;
                commit_cnt <= commit_cnt + 32'd1;
                if (ld_bad) begin
                    // Illegal load type retires without touching the write port
                    load_err <= 1'b1;
                end else begin
                    rd_wen  <= ld_wen & (ld_rd != 4'd0);
                    rd_addr <= ld_rd;
                    rd_data <= ld_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_wbu.sv
// Scoreboard bench for wbu: the driver pushes expected retirements, a monitor
// pops and compares them whenever commit pulses.
module tb_wbu;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [3:0]  exu_rd;
    logic        exu_wen;
    logic [31:0] exu_data;
    logic        exu_is_load;
    logic [2:0]  exu_funct3;
    logic [1:0]  exu_addr_lo;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        rd_wen;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        commit;
    logic        load_err;
    logic        pend_valid;
    logic [3:0]  pend_rd;
    logic [31:0] commit_cnt;

    wbu dut (
        .clk        (clk),
        .rst        (rst),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_rd     (exu_rd),
        .exu_wen    (exu_wen),
        .exu_data   (exu_data),
        .exu_is_load(exu_is_load),
        .exu_funct3 (exu_funct3),
        .exu_addr_lo(exu_addr_lo),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .rd_wen     (rd_wen),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .commit     (commit),
        .load_err   (load_err),
        .pend_valid (pend_valid),
        .pend_rd    (pend_rd),
        .commit_cnt (commit_cnt)
    );

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] model_cnt = '0;
    logic [3:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] last_cnt  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load result from the architectural rules, using plain arithmetic
    function automatic logic [31:0] load_ref(input int unsigned f3, input int unsigned lo,
                                             input logic [31:0] w, output logic legal);
        int unsigned word;
        int unsigned b;
        int unsigned h;
        word  = w;
        b     = (word >> (8 * lo)) % 256;
        h     = (word >> (16 * (lo / 2))) % 65536;
        legal = 1'b1;
        case (f3)
            0:       return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            1:       return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            2:       return w;
            4:       return b;
            5:       return h;
            default: begin
                legal = 1'b0;
                return '0;
            end
        endcase
    endfunction

    function automatic exp_t make_exp(input logic wen, input logic [3:0] rd,
                                      input logic [31:0] data, input logic err);
        exp_t e;
        model_cnt = model_cnt + 32'd1;
        e.wen  = wen && (rd != 4'd0) && !err;
        e.addr = rd;
        e.data = data;
        e.err  = err;
        e.cnt  = model_cnt;
        return e;
    endfunction

    // Monitor: compare every retirement against the scoreboard and check idle cycles hold
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (commit) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_wen", {31'd0, rd_wen}, {31'd0, e.wen});
                    chk("load_err", {31'd0, load_err}, {31'd0, e.err});
                    chk("commit_cnt", commit_cnt, e.cnt);
                    if (!e.err) begin
                        last_addr = e.addr;
                        last_data = e.data;
                    end
                    chk("rd_addr", {28'd0, rd_addr}, {28'd0, last_addr});
                    chk("rd_data", rd_data, last_data);
                    last_cnt = e.cnt;
                end
            end else begin
                chk("idle_pulses", {30'd0, rd_wen, load_err}, 32'd0);
                chk("hold_addr", {28'd0, rd_addr}, {28'd0, last_addr});
                chk("hold_data", rd_data, last_data);
                chk("hold_cnt", commit_cnt, last_cnt);
            end
        end
    end

    task automatic send_alu(input logic [3:0] rd, input logic wen, input logic [31:0] data);
        chk("ready_idle", {31'd0, exu_ready}, 32'd1);
        chk("pend_idle", {27'd0, pend_valid, pend_rd}, 32'd0);
        exu_valid   = 1'b1;
        exu_is_load = 1'b0;
        exu_rd      = rd;
        exu_wen     = wen;
        exu_data    = data;
        exu_funct3  = 3'($urandom);
        exu_addr_lo = 2'($urandom);
        exp_q.push_back(make_exp(wen, rd, data, 1'b0));
        @(negedge clk);
        exu_valid = 1'b0;
    endtask

    task automatic send_load(input logic [3:0] rd, input logic wen, input logic [2:0] f3,
                             input logic [1:0] lo, input int unsigned gap, input logic [31:0] rdata);
        logic        legal;
        logic [31:0] v;
        exu_valid   = 1'b1;
        exu_is_load = 1'b1;
        exu_rd      = rd;
        exu_wen     = wen;
        exu_funct3  = f3;
        exu_addr_lo = lo;
        exu_data    = $urandom;
        @(negedge clk);
        // A stalled upstream request stays presented and must not be taken
        exu_is_load = 1'($urandom);
        exu_rd      = 4'($urandom);
        exu_wen     = 1'b1;
        for (int unsigned i = 0; i <= gap; i++) begin
            chk("ready_wait", {31'd0, exu_ready}, 32'd0);
            chk("pend_valid", {31'd0, pend_valid}, 32'd1);
            chk("pend_rd", {28'd0, pend_rd}, {28'd0, rd});
            if (i < gap) @(negedge clk);
        end
        v = load_ref(f3, lo, rdata, legal);
        lsu_rvalid = 1'b1;
        lsu_rdata  = rdata;
        exp_q.push_back(make_exp(wen, rd, v, !legal));
        @(negedge clk);
        lsu_rvalid = 1'b0;
        exu_valid  = 1'b0;
    endtask

    task automatic idle(input int unsigned n, input logic stray);
        for (int unsigned i = 0; i < n; i++) begin
            exu_valid  = 1'b0;
            lsu_rvalid = stray;
            lsu_rdata  = $urandom;
            @(negedge clk);
            lsu_rvalid = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_cnt = '0;
        last_addr = '0;
        last_data = '0;
        last_cnt  = '0;
    endtask

    initial begin
        int unsigned op;
        rst         = 1'b1;
        exu_valid   = 1'b0;
        exu_rd      = '0;
        exu_wen     = 1'b0;
        exu_data    = '0;
        exu_is_load = 1'b0;
        exu_funct3  = '0;
        exu_addr_lo = '0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        #1;
        chk("rst_outputs", {29'd0, rd_wen, commit, load_err}, 32'd0);
        chk("rst_pend", {27'd0, pend_valid, pend_rd}, 32'd0);
        chk("rst_addr", {28'd0, rd_addr}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_cnt", commit_cnt, 32'd0);
        chk("rst_ready", {31'd0, exu_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First transfer right after reset release, then the directed load cases
        send_alu(4'd5, 1'b1, 32'h1234_5678);
        send_load(4'd7, 1'b1, 3'd0, 2'd3, 2, 32'h80FF_0011);
        send_load(4'd9, 1'b1, 3'd5, 2'd2, 1, 32'hBEEF_1234);
        send_load(4'd3, 1'b1, 3'd3, 2'd0, 0, 32'hDEAD_BEEF);
        idle(2, 1'b1);

        // Asynchronous reset in the middle of a load wait
        exu_valid   = 1'b1;
        exu_is_load = 1'b1;
        exu_rd      = 4'd11;
        exu_wen     = 1'b1;
        exu_funct3  = 3'd2;
        @(negedge clk);
        exu_valid = 1'b0;
        chk("pend_before_rst", {31'd0, pend_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_outputs", {29'd0, rd_wen, commit, load_err}, 32'd0);
        chk("arst_pend", {27'd0, pend_valid, pend_rd}, 32'd0);
        chk("arst_cnt", commit_cnt, 32'd0);
        chk("arst_data", {rd_data[31:4], rd_addr}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b1);
        chk("post_rst_cnt", commit_cnt, 32'd0);

        // rd=0 retirement followed by three back-to-back writes
        send_alu(4'd0, 1'b1, 32'hFFFF_FFFF);
        send_alu(4'd1, 1'b1, 32'h0000_0001);
        send_alu(4'd2, 1'b1, 32'h0000_0002);
        send_alu(4'd15, 1'b1, 32'hA5A5_A5A5);
        idle(2, 1'b0);
        chk("cnt_after_four", commit_cnt, 32'd4);

        // Counter wrap from all-ones
        force dut.commit_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt;
        model_cnt = 32'hFFFF_FFFF;
        last_cnt  = 32'hFFFF_FFFF;
        send_alu(4'd4, 1'b1, 32'h0BAD_F00D);
        idle(2, 1'b0);
        chk("cnt_wrap", commit_cnt, 32'd0);

        // Randomized mix of ALU ops, loads of every funct3, and stray LSU pulses
        for (int unsigned n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                send_alu(4'($urandom), 1'($urandom_range(0, 3) != 0), $urandom);
            end else if (op <= 7) begin
                send_load(4'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom),
                          2'($urandom), $urandom_range(0, 3), $urandom);
            end else begin
                idle(1, op == 8);
            end
        end
        idle(3, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
